// File: rtl/wb_machine_timer_pkg.sv
// Shared definitions for the Wishbone RISC-V machine timer: register word
// offsets, control bit positions, bus FSM states and a byte-lane merge helper.
package wb_machine_timer_pkg;

  localparam logic [2:0] TIMER_OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] TIMER_OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] TIMER_OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TIMER_OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TIMER_OFF_CTRL        = 3'd4;

  localparam int unsigned CTRL_EN = 0;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } bus_state_t;

  // Replace only the bytes of old_word whose lane is enabled in sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    result = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_machine_timer_prescaler.sv
// Divides clk_i by PRESCALE while enabled; tick marks the cycle in which
// mtime advances. The count is held at zero whenever the timer is disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count_q;

  assign tick = en && (count_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (!en || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/wb_machine_timer.sv
// Wishbone classic slave holding the RISC-V mtime/mtimecmp pair and an enable
// bit; raises timer_irq_o as a registered level while mtime >= mtimecmp.
module wb_machine_timer
  import wb_machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE       = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        timer_irq_o
);

  bus_state_t  state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [31:0] hi_shadow_q;
  logic        irq_q;

  logic        tick;
  logic [2:0]  offset;
  logic        mapped;
  logic        req;
  logic        wr;
  logic        rd_lo;
  logic [31:0] rd_data;
  logic        unused_adr;

  assign offset     = adr_i[4:2];
  assign mapped     = (offset <= TIMER_OFF_CTRL);
  assign req        = cyc_i && stb_i && (state_q == ST_IDLE);
  assign wr         = req && we_i && mapped;
  assign rd_lo      = req && !we_i && (offset == TIMER_OFF_MTIME_LO);
  assign unused_adr = ^adr_i[1:0];

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (en_q),
    .tick  (tick)
  );

  always_comb begin
    rd_data = '0;
    case (offset)
      TIMER_OFF_MTIME_LO:    rd_data = mtime_q[31:0];
      TIMER_OFF_MTIME_HI:    rd_data = hi_shadow_q;
      TIMER_OFF_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
      TIMER_OFF_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
      TIMER_OFF_CTRL:        rd_data[CTRL_EN] = en_q;
      default:               rd_data = '0;
    endcase
  end

  // The bus write is merged on top of the incremented count, so written bytes
  // win over a coincident tick while unwritten bytes still carry it.
  always_comb begin
    mtime_inc  = mtime_q + 64'(tick);
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    if (wr) begin
      case (offset)
        TIMER_OFF_MTIME_LO:
          mtime_d[31:0] = merge_bytes(mtime_inc[31:0], dat_i, sel_i);
        TIMER_OFF_MTIME_HI:
          mtime_d[63:32] = merge_bytes(mtime_inc[63:32], dat_i, sel_i);
        TIMER_OFF_MTIMECMP_LO:
          mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], dat_i, sel_i);
        TIMER_OFF_MTIMECMP_HI:
          mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], dat_i, sel_i);
        TIMER_OFF_CTRL:
          if (sel_i[0]) en_d = dat_i[CTRL_EN];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          state_d = ST_RESP;
          if (mapped) begin
            ack_d = 1'b1;
            dat_d = rd_data;
          end else begin
            err_d = 1'b1;
            dat_d = '0;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RESET;
      en_q        <= 1'b0;
      hi_shadow_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
      if (rd_lo) hi_shadow_q <= mtime_q[63:32];
    end
  end

  assign dat_o       = dat_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rty_o       = 1'b0;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_machine_timer.sv
// Randomised scoreboard bench for wb_machine_timer: a cycle-level model of the
// timer's register rules predicts every bus response and the interrupt level.
module tb_wb_machine_timer;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [4:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack, err, rty, irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  wb_machine_timer #(
    .PRESCALE(P),
    .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .adr_i      (adr),
    .sel_i      (sel),
    .dat_i      (wdat),
    .dat_o      (rdat),
    .ack_o      (ack),
    .err_o      (err),
    .rty_o      (rty),
    .timer_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Reference model: state as visible to software.
  logic [63:0] m_mtime, m_cmp, n_mtime, n_cmp;
  logic [31:0] m_shadow, n_shadow;
  bit          m_en, n_en, m_irq, m_busy;
  int unsigned m_enabled_cycles;
  int unsigned m_off;
  exp_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime = '0; m_cmp = '1; m_shadow = '0; m_en = 0; m_irq = 0; m_busy = 0;
      m_enabled_cycles = 0;
      exp_q.delete();
    end else begin
      n_mtime = m_mtime; n_cmp = m_cmp; n_shadow = m_shadow; n_en = m_en;
      if (m_en) begin
        m_enabled_cycles++;
        if (m_enabled_cycles == P) begin
          m_enabled_cycles = 0;
          n_mtime = m_mtime + 64'd1;
        end
      end else begin
        m_enabled_cycles = 0;
      end
      if (cyc && stb && !m_busy) begin
        m_busy = 1;
        m_off = int'(adr[4:2]);
        m_e.is_err = (m_off > 4);
        m_e.chk_data = m_e.is_err || !we;
        m_e.data = '0;
        if (!m_e.is_err) begin
          case (m_off)
            0: m_e.data = m_mtime[31:0];
            1: m_e.data = m_shadow;
            2: m_e.data = m_cmp[31:0];
            3: m_e.data = m_cmp[63:32];
            default: m_e.data = {31'd0, m_en};
          endcase
          if (we) begin
            case (m_off)
              0: n_mtime[31:0]  = lanes(n_mtime[31:0], wdat, sel);
              1: n_mtime[63:32] = lanes(n_mtime[63:32], wdat, sel);
              2: n_cmp[31:0]    = lanes(n_cmp[31:0], wdat, sel);
              3: n_cmp[63:32]   = lanes(n_cmp[63:32], wdat, sel);
              default: if (sel[0]) n_en = wdat[0];
            endcase
          end else if (m_off == 0) begin
            n_shadow = m_mtime[63:32];
          end
        end
        exp_q.push_back(m_e);
      end else begin
        m_busy = 0;
      end
      m_irq = (m_mtime >= m_cmp);
      m_mtime = n_mtime; m_cmp = n_cmp; m_shadow = n_shadow; m_en = n_en;
    end
  end

  // Monitor: every cycle the interrupt level is compared, and a response must
  // appear exactly when the model has one outstanding.
  always @(negedge clk) begin
    if (rst_n) begin
      check("irq", 64'(irq), 64'(m_irq));
      check("rty", 64'(rty), 64'd0);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack", 64'(ack), 64'(!e.is_err));
        check("err", 64'(err), 64'(e.is_err));
        if (e.chk_data) check("rdata", 64'(rdat), 64'(e.data));
      end else begin
        check("idle_ack_err", {62'd0, ack, err}, 64'd0);
      end
    end
  end

  task automatic access(input bit w, input logic [4:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    access(1'b0, a, 4'hF, $urandom);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    access(1'b1, a, 4'hF, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_outputs", {29'd0, ack, err, irq, rdat}, 64'd0);

    for (int i = 0; i < 5; i++) rd(5'(i * 4));

    access(1'b1, 5'h08, 4'b0100, 32'hAABB_CCDD);
    rd(5'h08);

    rd(5'h18);
    access(1'b1, 5'h1C, 4'hF, 32'h1234_5678);
    rd(5'h15);
    for (int i = 0; i < 5; i++) rd(5'(i * 4 + 3));

    wr(5'h10, 32'd1);
    idle(40);
    rd(5'h00);
    rd(5'h04);

    wr(5'h10, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'd1);
    idle(P + 2);
    rd(5'h00);
    idle(3 * P);
    rd(5'h04);
    rd(5'h00);

    wr(5'h10, 32'd0);
    wr(5'h00, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'h20);
    wr(5'h10, 32'd1);
    idle(32 * P + 10);
    wr(5'h0C, 32'hFFFF_FFFF);
    idle(3);

    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFF - 32'(2 * P));
    idle(4 * P);
    rd(5'h00);
    rd(5'h04);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & 32'h0000_00FF;
      access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             4'($urandom_range(0, 15)), d);
      idle($urandom_range(0, 3));
    end

    wr(5'h10, 32'd1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h00; sel = 4'hF;
    @(posedge clk);
    #1;
    check("ack_before_reset", 64'(ack), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ack_dropped_by_reset", {62'd0, ack, err}, 64'd0);
    cyc = 1'b0; stb = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    rd(5'h00);
    rd(5'h10);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
